ray_scan_gen: RTL and testbench
===============================

# ray_scan_gen

Frame-level primary-ray generator for the tracer front end.
- Rasters an H_RES x V_RES screen (optionally subsampled) and feeds each pixel into the `eye_to_pixel` direction pipeline, which has a fixed latency and no stall input.
- Latches the head position once per frame, so all rays of a frame share one eye point.
- Returns normalized directions tagged with pixel coordinates through an output FIFO with valid/ready backpressure, so downstream intersection stages may stall without losing rays.

## Interface
Parameters:
- H_RES, 512, screen width in pixels; ≤2048, multiple of STEP
- V_RES, 384, screen height in pixels; ≤1024, multiple of STEP
- STEP, 1, raster stride in both axes (1, 2 or 4)
- PIPE_LATENCY, 117, cycles from direction-pipeline valid_in to dir_valid; must match the instantiated pipeline
- FIFO_DEPTH, 128, output FIFO entries, power of two; also the credit limit

Ports:
- clk_in, input, 1, sole clock
- rst_in, input, 1, asynchronous active-high reset; `~rst_in` drives the float-IP aresetn
- start_in, input, 1, pulse; begins a frame from IDLE, ignored elsewhere
- continuous_in, input, 1, sampled at frame end; 1 = auto-restart the next frame
- head_x_float / head_y_float / head_z_float, input, 32 each, IEEE-754 eye position, sampled only in ARM
- ray_ready_in, input, 1, consumer accepts the head entry
- ray_valid_out, output, 1, FIFO non-empty
- dir_x / dir_y / dir_z, output, 32 each, normalized direction
- ray_x_out, output, 11, pixel x of the ray
- ray_y_out, output, 10, pixel y of the ray
- ray_last_out, output, 1, final pixel of the frame
- busy_out, output, 1, state ≠ IDLE, or rays in flight, or FIFO non-empty
- frame_done_out, output, 1, one-cycle pulse when the last ray is accepted

## Operation
State machine: IDLE, ARM, SCAN, DRAIN.
- IDLE -> ARM on start_in.
- ARM: wait until inflight == 0. Then latch the head registers and go to SCAN on the next cycle. The pipeline's head inputs come only from these latched registers, so the head position is stable for the whole frame.
- SCAN:
  - Issue one pixel per cycle when `inflight + fifo_count < FIFO_DEPTH`.
  - Issue order: x = 0, STEP, …, H_RES−STEP; then y += STEP, x back to 0.
  - Issuing pixel (H_RES−STEP, V_RES−STEP) marks the tag last and goes to DRAIN.
- DRAIN:
  - If continuous_in = 1 → ARM.
  - Otherwise → IDLE once inflight == 0.
  - Raster counters reset to 0 on leaving SCAN.

Issue:
- Drives pipeline valid_in with {x, y}.
- Pushes tag {x, y, last} into a tag FIFO (depth FIFO_DEPTH); inflight += 1.

Pipeline output:
- On dir_valid, pop the tag FIFO and write {dir, tag} into the output FIFO; inflight −= 1.
- An issue and a retire in the same cycle leave inflight unchanged.

Credit rule:
- Guarantees the output FIFO never overflows and no pipeline result is dropped, because the pipeline cannot stall.
- A write to a full output FIFO is a bug; assert in simulation.

Output FIFO:
- First-word-fall-through; pop on ray_valid_out && ray_ready_in.
- Simultaneous push and pop on a full FIFO is legal.

## Timing
- Reset values: all outputs 0, state IDLE, inflight 0, both FIFOs empty, head registers 0.
- Reset mid-frame:
  - Everything clears immediately (asynchronous).
  - The pipeline is reset through aresetn, so no stale dir_valid appears afterwards.
- start_in at cycle t: ARM at t+1; first issue at t+2 if the pipeline is empty.
- Latency:
  - Issue at cycle n → dir_valid at n+PIPE_LATENCY.
  - ray_valid_out at n+PIPE_LATENCY+1 if the FIFO was empty.
- Throughput: 1 ray/cycle when ray_ready_in is held high.
- Rays per frame: (H_RES/STEP)·(V_RES/STEP).
- Frame boundary in continuous mode: at least PIPE_LATENCY+1 idle-issue cycles (the ARM drain wait).
- frame_done_out: the cycle after the ray_last_out entry is popped.

## Test plan
- H_RES=8, V_RES=4, STEP=1, ray_ready_in=1, start pulse → 32 rays in raster order; (0,0) appears at cycle start+2+PIPE_LATENCY+1; ray_last_out only on (7,3); one frame_done_out; then IDLE with busy_out=0.
- STEP=2, same screen → 8 rays: (0,0),(2,0),(4,0),(6,0),(0,2)…(6,2).
- FIFO_DEPTH=8, ray_ready_in=0 for 500 cycles → issue stops with inflight+fifo_count=8; release → all 32 rays delivered exactly once, in order, with no overflow assertion.
- continuous_in=1, head_z changed from −300.0 to −500.0 mid-frame → frame 1 directions all use −300.0; the frame 2 latch takes −500.0; pixel (x,y) directions match the float reference model for their respective head values.
- rst_in asserted 20 cycles after the first issue → outputs 0 on the same edge; no ray_valid_out during the following 2·PIPE_LATENCY cycles; a new start produces a clean full frame.
- Random ray_ready_in at 30 % duty over 3 frames → sequence of (x,y) tags, counts and ray_last_out positions identical to the ready=1 run.

Source files
------------

// File: rtl/ray_if.sv
// ray_if: valid/ready ray stream from the scan generator to the intersection
// stages, carrying the normalized direction and its pixel tag.
interface ray_if;
  logic        ray_valid_out;
  logic        ray_ready_in;
  logic [31:0] dir_x;
  logic [31:0] dir_y;
  logic [31:0] dir_z;
  logic [10:0] ray_x_out;
  logic [9:0]  ray_y_out;
  logic        ray_last_out;

  modport master (
    output ray_valid_out, dir_x, dir_y, dir_z,
    output ray_x_out, ray_y_out, ray_last_out,
    input  ray_ready_in
  );

  modport slave (
    input  ray_valid_out, dir_x, dir_y, dir_z,
    input  ray_x_out, ray_y_out, ray_last_out,
    output ray_ready_in
  );
endinterface

// File: rtl/ray_scan_gen.sv
// ray_scan_gen: per-frame raster issue into a fixed-latency direction
// pipeline, tag FIFO, and credit-limited FWFT output FIFO.
module eye_to_pixel #(
  parameter int LATENCY = 117
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        valid_in,
  input  logic [10:0] px,
  input  logic [9:0]  py,
  input  logic [31:0] head_x,
  input  logic [31:0] head_y,
  input  logic [31:0] head_z,
  output logic        dir_valid,
  output logic [31:0] dir_x,
  output logic [31:0] dir_y,
  output logic [31:0] dir_z
);
  // Fixed-latency stand-in: result mixes eye and pixel so both are traceable.
  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] vld_d;
  logic [95:0]        dat_q [LATENCY];

  assign vld_d = LATENCY'({vld_q, valid_in});

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) vld_q <= '0;
    else          vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    dat_q[0] <= {head_x ^ {21'b0, px}, head_y ^ {22'b0, py}, head_z};
    for (int i = 1; i < LATENCY; i++) dat_q[i] <= dat_q[i-1];
  end

  assign dir_valid = vld_q[LATENCY-1];
  assign {dir_x, dir_y, dir_z} = dat_q[LATENCY-1];
endmodule

module ray_scan_gen #(
  parameter int H_RES        = 512,
  parameter int V_RES        = 384,
  parameter int STEP         = 1,
  parameter int PIPE_LATENCY = 117,
  parameter int FIFO_DEPTH   = 128
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic        continuous_in,
  input  logic [31:0] head_x_float,
  input  logic [31:0] head_y_float,
  input  logic [31:0] head_z_float,
  output logic        busy_out,
  output logic        frame_done_out,
  ray_if.master       ray
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [10:0]   X_LAST = 11'(H_RES - STEP);
  localparam logic [9:0]    Y_LAST = 10'(V_RES - STEP);
  localparam logic [10:0]   X_STEP = 11'(STEP);
  localparam logic [9:0]    Y_STEP = 10'(STEP);
  localparam logic [CW-1:0] DEPTH  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ARM, SCAN, DRAIN} state_t;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic        last;
  } tag_t;

  typedef struct packed {
    logic [31:0] dx;
    logic [31:0] dy;
    logic [31:0] dz;
    tag_t        tag;
  } ray_t;

  state_t        state_q, state_d;
  logic [10:0]   x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic [31:0]   hx_q, hx_d, hy_q, hy_d, hz_q, hz_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [CW-1:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic          frame_done_q, frame_done_d;

  logic          issue, last, pop, ovalid, dir_valid;
  logic [CW-1:0] ocount;
  logic [31:0]   dx, dy, dz;
  tag_t          tag_in, tag_out;
  ray_t          head;
  tag_t          tag_mem [FIFO_DEPTH];
  ray_t          out_mem [FIFO_DEPTH];

  assign ocount  = out_wr_q - out_rd_q;
  assign ovalid  = ocount != '0;
  assign pop     = ovalid && ray.ray_ready_in;
  assign head    = out_mem[out_rd_q[AW-1:0]];
  assign tag_out = tag_mem[tag_rd_q[AW-1:0]];
  assign tag_in  = {x_q, y_q, last};

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    hx_d    = hx_q;
    hy_d    = hy_q;
    hz_d    = hz_q;
    issue   = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: if (start_in) state_d = ARM;
      ARM: begin
        // Latch only with an empty pipe so one frame sees one eye point.
        if (inflight_q == '0) begin
          hx_d    = head_x_float;
          hy_d    = head_y_float;
          hz_d    = head_z_float;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (inflight_q + ocount < DEPTH) begin
          issue = 1'b1;
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              y_d     = '0;
              last    = 1'b1;
              state_d = DRAIN;
            end else begin
              y_d = y_q + Y_STEP;
            end
          end else begin
            x_d = x_q + X_STEP;
          end
        end
      end
      DRAIN: begin
        if (continuous_in)          state_d = ARM;
        else if (inflight_q == '0)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    unique case ({issue, dir_valid})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: ;
    endcase
    tag_wr_d     = tag_wr_q + CW'(issue);
    tag_rd_d     = tag_rd_q + CW'(dir_valid);
    out_wr_d     = out_wr_q + CW'(dir_valid);
    out_rd_d     = out_rd_q + CW'(pop);
    frame_done_d = pop && head.tag.last;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      hx_q         <= '0;
      hy_q         <= '0;
      hz_q         <= '0;
      inflight_q   <= '0;
      tag_wr_q     <= '0;
      tag_rd_q     <= '0;
      out_wr_q     <= '0;
      out_rd_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      hx_q         <= hx_d;
      hy_q         <= hy_d;
      hz_q         <= hz_d;
      inflight_q   <= inflight_d;
      tag_wr_q     <= tag_wr_d;
      tag_rd_q     <= tag_rd_d;
      out_wr_q     <= out_wr_d;
      out_rd_q     <= out_rd_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (issue)     tag_mem[tag_wr_q[AW-1:0]] <= tag_in;
    if (dir_valid) out_mem[out_wr_q[AW-1:0]] <= {dx, dy, dz, tag_out};
  end

  // The pipe cannot stall, so a push into a full FIFO means lost rays.
  always_ff @(posedge clk_in) begin
    if (!rst_in) assert (!(dir_valid && ocount == DEPTH && !pop));
  end

  eye_to_pixel #(.LATENCY(PIPE_LATENCY)) u_pipe (
    .clk       (clk_in),
    .aresetn   (~rst_in),
    .valid_in  (issue),
    .px        (x_q),
    .py        (y_q),
    .head_x    (hx_q),
    .head_y    (hy_q),
    .head_z    (hz_q),
    .dir_valid (dir_valid),
    .dir_x     (dx),
    .dir_y     (dy),
    .dir_z     (dz)
  );

  assign ray.ray_valid_out = ovalid;
  assign ray.dir_x         = ovalid ? head.dx : '0;
  assign ray.dir_y         = ovalid ? head.dy : '0;
  assign ray.dir_z         = ovalid ? head.dz : '0;
  assign ray.ray_x_out     = ovalid ? head.tag.x : '0;
  assign ray.ray_y_out     = ovalid ? head.tag.y : '0;
  assign ray.ray_last_out  = ovalid && head.tag.last;
  assign busy_out          = (state_q != IDLE) || (inflight_q != '0) || ovalid;
  assign frame_done_out    = frame_done_q;
endmodule

// File: tb/tb_ray_scan_gen.sv
// Bench for ray_scan_gen: raster/eye reference queue, backpressure,
// continuous frames with a head change, mid-frame reset, STEP=2 screen.
`timescale 1ns/1ps
module tb_ray_scan_gen;
  localparam int H  = 8;
  localparam int V  = 4;
  localparam int L  = 12;
  localparam int D  = 8;
  localparam int L2 = 5;
  localparam int D2 = 4;
  localparam logic [31:0] HX    = 32'h3F80_0000;
  localparam logic [31:0] HY    = 32'h4000_0000;
  localparam logic [31:0] HZ300 = 32'hC396_0000;
  localparam logic [31:0] HZ500 = 32'hC3FA_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, start2 = 1'b0;
  logic        cont = 1'b0, cont2 = 1'b0;
  logic [31:0] hx = HX, hy = HY, hz = HZ300;
  logic        busy, fdone, busy2, fdone2;

  ray_if r1 ();
  ray_if r2 ();

  always #5 clk = ~clk;

  ray_scan_gen #(
    .H_RES(H), .V_RES(V), .STEP(1), .PIPE_LATENCY(L), .FIFO_DEPTH(D)
  ) u_dut (
    .clk_in(clk), .rst_in(rst), .start_in(start), .continuous_in(cont),
    .head_x_float(hx), .head_y_float(hy), .head_z_float(hz),
    .busy_out(busy), .frame_done_out(fdone), .ray(r1)
  );

  ray_scan_gen #(
    .H_RES(H), .V_RES(V), .STEP(2), .PIPE_LATENCY(L2), .FIFO_DEPTH(D2)
  ) u_dut2 (
    .clk_in(clk), .rst_in(rst), .start_in(start2), .continuous_in(cont2),
    .head_x_float(hx), .head_y_float(hy), .head_z_float(hz),
    .busy_out(busy2), .frame_done_out(fdone2), .ray(r2)
  );

  typedef struct {
    int          x;
    int          y;
    bit          last;
    logic [31:0] dx;
    logic [31:0] dy;
    logic [31:0] dz;
  } ray_exp_t;

  ray_exp_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fdones = 0;
  int first_cyc = -1;
  int t0 = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_frame(input int step, input logic [31:0] ex,
                           input logic [31:0] ey, input logic [31:0] ez);
    ray_exp_t e;
    for (int y = 0; y < V; y += step) begin
      for (int x = 0; x < H; x += step) begin
        e.x    = x;
        e.y    = y;
        e.last = (x == H - step) && (y == V - step);
        e.dx   = ex ^ 32'(x);
        e.dy   = ey ^ 32'(y);
        e.dz   = ez;
        q.push_back(e);
      end
    end
  endtask

  task automatic run(input int sel, input int budget, input int duty,
                     input int npops);
    logic        v, rdy, ol, fd;
    logic [10:0] ox;
    logic [9:0]  oy;
    logic [31:0] odx, ody, odz;
    ray_exp_t    e;
    int          n;
    n = 0;
    for (int c = 0; c < budget && n < npops; c++) begin
      @(negedge clk);
      rdy = ($urandom_range(99) < duty);
      if (sel == 0) begin
        r1.ray_ready_in = rdy;
        v = r1.ray_valid_out; ox = r1.ray_x_out; oy = r1.ray_y_out;
        ol = r1.ray_last_out; odx = r1.dir_x; ody = r1.dir_y;
        odz = r1.dir_z; fd = fdone;
      end else begin
        r2.ray_ready_in = rdy;
        v = r2.ray_valid_out; ox = r2.ray_x_out; oy = r2.ray_y_out;
        ol = r2.ray_last_out; odx = r2.dir_x; ody = r2.dir_y;
        odz = r2.dir_z; fd = fdone2;
      end
      if (fd) fdones++;
      if (v && first_cyc < 0) first_cyc = cyc;
      if (v && rdy) begin
        n++;
        if (q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL extra_ray observed=(%0d,%0d) expected=none", ox, oy);
        end else begin
          e = q.pop_front();
          chk("ray_x", ox, e.x);
          chk("ray_y", oy, e.y);
          chk("ray_last", ol, e.last);
          chk("dir_x", odx, e.dx);
          chk("dir_y", ody, e.dy);
          chk("dir_z", odz, e.dz);
        end
      end
    end
  endtask

  task automatic wait_idle(input int sel, input int budget);
    logic b;
    b = 1'b1;
    for (int c = 0; c < budget && b; c++) begin
      @(negedge clk);
      if ((sel == 0) ? fdone : fdone2) fdones++;
      b = (sel == 0) ? busy : busy2;
    end
    chk("idle_busy", b, 0);
  endtask

  task automatic pulse_start(input int sel);
    @(negedge clk);
    if (sel == 0) start = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start2 = 1'b0;
    t0 = cyc;
    fdones = 0;
    first_cyc = -1;
  endtask

  initial begin
    r1.ray_ready_in = 1'b0;
    r2.ray_ready_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", r1.ray_valid_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dir_x", r1.dir_x, 0);
    chk("rst_fdone", fdone, 0);
    rst = 1'b0;

    // single frame, ready held high
    add_frame(1, HX, HY, HZ300);
    pulse_start(0);
    run(0, 400, 100, 32);
    chk("t1_left", q.size(), 0);
    wait_idle(0, 50);
    chk("t1_first_lat", first_cyc - t0, L + 2);
    chk("t1_fdone", fdones, 1);

    // STEP=2 screen on the second instance
    add_frame(2, HX, HY, HZ300);
    pulse_start(1);
    run(1, 300, 100, 8);
    chk("t2_left", q.size(), 0);
    wait_idle(1, 50);
    chk("t2_first_lat", first_cyc - t0, L2 + 2);
    chk("t2_fdone", fdones, 1);

    // backpressure: issue must stop on the credit limit
    add_frame(1, HX, HY, HZ300);
    pulse_start(0);
    run(0, 100, 0, 1000);
    chk("t3_credit", 64'(u_dut.inflight_q + u_dut.ocount), D);
    chk("t3_valid_held", r1.ray_valid_out, 1);
    chk("t3_busy_held", busy, 1);
    run(0, 600, 100, 32);
    chk("t3_left", q.size(), 0);
    wait_idle(0, 50);
    chk("t3_fdone", fdones, 1);

    // continuous mode, eye z changed during frame 1
    cont = 1'b1;
    add_frame(1, HX, HY, HZ300);
    add_frame(1, HX, HY, HZ500);
    pulse_start(0);
    run(0, 400, 100, 5);
    hz = HZ500;
    run(0, 800, 100, 27);
    cont = 1'b0;
    run(0, 800, 100, 32);
    chk("t4_left", q.size(), 0);
    wait_idle(0, 100);
    chk("t4_fdone", fdones, 2);

    // reset in mid-frame
    hz = HZ300;
    pulse_start(0);
    run(0, 22, 0, 1000);
    chk("t5_pre_valid", r1.ray_valid_out, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", r1.ray_valid_out, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_dir_z", r1.dir_z, 0);
    chk("t5_rst_fdone", fdone, 0);
    @(negedge clk);
    rst = 1'b0;
    first_cyc = -1;
    run(0, 2 * L, 100, 1000);
    chk("t5_quiet", first_cyc, -1);
    add_frame(1, HX, HY, HZ300);
    pulse_start(0);
    run(0, 400, 100, 32);
    chk("t5_left", q.size(), 0);
    wait_idle(0, 50);
    chk("t5_fdone", fdones, 1);

    // three continuous frames under random 30% ready
    cont = 1'b1;
    add_frame(1, HX, HY, HZ300);
    add_frame(1, HX, HY, HZ300);
    add_frame(1, HX, HY, HZ300);
    pulse_start(0);
    run(0, 3000, 30, 64);
    cont = 1'b0;
    run(0, 3000, 30, 32);
    chk("t6_left", q.size(), 0);
    wait_idle(0, 100);
    chk("t6_fdone", fdones, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
